sprite_blitter: RTL and testbench

SPRITE_BLITTER -- requirements
Module: sprite_blitter

---
 rtl/sprite_blitter.sv | 124 ++++++++++++
 tb/tb_sprite_blitter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_blitter.sv
// Sprite blitter: streams a SPR_W x SPR_H sprite from ROM into a frame buffer,
// with optional horizontal mirroring, transparency (index 0) and screen clipping.
module sprite_blitter #(
  parameter int SPR_W = 28,
  parameter int SPR_H = 42,
  parameter int FB_W  = 640,
  parameter int FB_H  = 480
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        start,
  input  logic [18:0] sprite_base,
  input  logic [9:0]  pos_x,
  input  logic [9:0]  pos_y,
  input  logic        flip,
  output logic [18:0] rom_addr,
  input  logic [4:0]  rom_data,
  output logic        fb_we,
  output logic [18:0] fb_addr,
  output logic [4:0]  fb_data,
  output logic        busy,
  output logic        done
);

  localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [18:0]   base_q, base_d;
  logic [9:0]    px_q, px_d;
  logic [9:0]    py_q, py_d;
  logic          flip_q, flip_d;
  logic          vld_p1_q, vld_p1_d;
  logic [10:0]   x_p1_q, x_p1_d;
  logic [10:0]   y_p1_q, y_p1_d;
  logic [CW-1:0] rom_col;

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    base_d   = base_q;
    px_d     = px_q;
    py_d     = py_q;
    flip_d   = flip_q;
    vld_p1_d = 1'b0;
    x_p1_d   = x_p1_q;
    y_p1_d   = y_p1_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          base_d  = sprite_base;
          px_d    = pos_x;
          py_d    = pos_y;
          flip_d  = flip;
          row_d   = '0;
          col_d   = '0;
        end
      end
      FETCH: begin
        // Screen coordinates follow the unmirrored column; only the ROM read is mirrored.
        vld_p1_d = 1'b1;
        x_p1_d   = {1'b0, px_q} + 11'(col_q);
        y_p1_d   = {1'b0, py_q} + 11'(row_q);
        if (col_q == CW'(SPR_W - 1)) begin
          col_d = '0;
          if (row_q == RW'(SPR_H - 1)) state_d = DRAIN;
          else                         row_d   = row_q + RW'(1);
        end else begin
          col_d = col_q + CW'(1);
        end
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      row_q    <= '0;
      col_q    <= '0;
      base_q   <= '0;
      px_q     <= '0;
      py_q     <= '0;
      flip_q   <= 1'b0;
      vld_p1_q <= 1'b0;
      x_p1_q   <= '0;
      y_p1_q   <= '0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      base_q   <= base_d;
      px_q     <= px_d;
      py_q     <= py_d;
      flip_q   <= flip_d;
      vld_p1_q <= vld_p1_d;
      x_p1_q   <= x_p1_d;
      y_p1_q   <= y_p1_d;
    end
  end

  // Stage p0: address issue. Stage p1: write decision against returned ROM data.
  always_comb begin
    rom_col  = flip_q ? (CW'(SPR_W - 1) - col_q) : col_q;
    rom_addr = '0;
    if (state_q == FETCH)
      rom_addr = base_q + 19'(row_q) * 19'(SPR_W) + 19'(rom_col);
    fb_we   = vld_p1_q && (rom_data != 5'd0) &&
              (x_p1_q < 11'(FB_W)) && (y_p1_q < 11'(FB_H));
    fb_addr = fb_we ? (19'(y_p1_q) * 19'(FB_W) + 19'(x_p1_q)) : '0;
    fb_data = fb_we ? rom_data : '0;
    busy    = (state_q != IDLE);
    done    = (state_q == DONE);
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// Randomized scoreboard bench for sprite_blitter: a pixel-level model predicts
// every frame buffer write and the completion edge of each blit.
module tb_sprite_blitter;

  localparam int W = 28;
  localparam int H = 42;
  localparam int LAT = W * H + 1;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        start;
  logic [18:0] sprite_base;
  logic [9:0]  pos_x, pos_y;
  logic        flip;
  logic [18:0] rom_addr;
  logic [4:0]  rom_data = 5'd0;
  logic        fb_we;
  logic [18:0] fb_addr;
  logic [4:0]  fb_data;
  logic        busy, done;

  sprite_blitter #(.SPR_W(W), .SPR_H(H), .FB_W(640), .FB_H(480)) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .sprite_base(sprite_base),
    .pos_x(pos_x), .pos_y(pos_y), .flip(flip), .rom_addr(rom_addr),
    .rom_data(rom_data), .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
    .busy(busy), .done(done)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [18:0] a;
    logic [4:0]  d;
  } wr_t;

  logic [4:0] rom [0:4095];
  wr_t wq[$];
  int  dq[$];
  int  cyc = 0;
  int  total = 0;
  int  bad = 0;
  int  wr_cnt = 0;
  int  done_cnt = 0;
  int  nd = 0;

  always @(posedge Clk) begin
    cyc      <= cyc + 1;
    rom_data <= rom[rom_addr[11:0]];
  end

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // mode 0: all opaque, 1: zero at even addresses, 2: any index including 0
  task automatic fill_rom(input int mode);
    for (int i = 0; i < 4096; i++) begin
      case (mode)
        0:       rom[i] = 5'($urandom_range(31, 1));
        1:       rom[i] = (i % 2 == 0) ? 5'd0 : 5'($urandom_range(31, 1));
        default: rom[i] = 5'($urandom_range(31, 0));
      endcase
    end
  endtask

  task automatic model_blit(input int b, input int x0, input int y0, input int f,
                            output int n);
    wr_t w;
    n = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        int cc, addr, x, y;
        cc   = (f != 0) ? (W - 1 - c) : c;
        addr = b + r * W + cc;
        x    = x0 + c;
        y    = y0 + r;
        if (rom[addr] != 5'd0 && x < 640 && y < 480) begin
          w.a = 19'(y * 640 + x);
          w.d = rom[addr];
          wq.push_back(w);
          n++;
        end
      end
    end
  endtask

  // Called between edges with the DUT idle; returns #1 after the sampling edge.
  task automatic go(input int b, input int x, input int y, input int f,
                    output int k, output int n);
    model_blit(b, x, y, f, n);
    sprite_base = 19'(b);
    pos_x       = 10'(x);
    pos_y       = 10'(y);
    flip        = f[0];
    start       = 1'b1;
    @(posedge Clk);
    #1;
    k = cyc;
    start = 1'b0;
    dq.push_back(k + LAT);
    nd++;
    check("busy_on_start", busy, 1);
    sprite_base = 19'($urandom);
    pos_x       = 10'($urandom);
    pos_y       = 10'($urandom);
    flip        = 1'($urandom);
  endtask

  task automatic wait_done(input int target);
    int i;
    i = 0;
    while (done_cnt < target && i < 3000) begin
      @(negedge Clk);
      i++;
    end
    if (done_cnt < target) check("done_timeout", done_cnt, target);
  endtask

  initial begin : monitor
    wr_t w;
    int  e;
    bit  post_done;
    post_done = 0;
    forever begin
      @(negedge Clk);
      if (!Reset) begin
        if (post_done) begin
          check("busy_after_done", busy, 0);
          post_done = 0;
        end
        if (fb_we) begin
          wr_cnt++;
          if (wq.size() == 0) check("unexpected_write", fb_addr, -1);
          else begin
            w = wq.pop_front();
            check("fb_addr", fb_addr, w.a);
            check("fb_data", fb_data, w.d);
          end
        end
        if (done) begin
          done_cnt++;
          post_done = 1;
          if (dq.size() == 0) check("unexpected_done", cyc, -1);
          else begin
            e = dq.pop_front();
            check("done_edge", cyc, e);
          end
          check("writes_left_at_done", wq.size(), 0);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int k, n, w0, b, x, y, f;
    Reset = 1'b1;
    start = 1'b0;
    sprite_base = '0;
    pos_x = '0;
    pos_y = '0;
    flip = 1'b0;
    fill_rom(0);
    repeat (3) @(negedge Clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_fb_we", fb_we, 0);
    check("rst_rom_addr", rom_addr, 0);
    check("rst_fb_addr", fb_addr, 0);
    check("rst_fb_data", fb_data, 0);
    Reset = 1'b0;

    // Opaque sprite at the origin; start on the first edge after reset release.
    w0 = wr_cnt;
    go(0, 0, 0, 0, k, n);
    check("t1_first_rom_addr", rom_addr, 0);
    wait_done(nd);
    @(negedge Clk);
    check("t1_writes", wr_cnt - w0, 1176);

    // Mirrored sprite at (100,50).
    fill_rom(0);
    go(0, 100, 50, 1, k, n);
    check("t2_first_rom_addr", rom_addr, 27);
    wait_done(nd);
    @(negedge Clk);

    // Transparent pixels at even ROM addresses.
    fill_rom(1);
    w0 = wr_cnt;
    go(0, 0, 0, 0, k, n);
    wait_done(nd);
    @(negedge Clk);
    check("t3_writes", wr_cnt - w0, 588);

    // Clipped at the bottom-right corner.
    fill_rom(0);
    w0 = wr_cnt;
    go(0, 630, 470, 0, k, n);
    wait_done(nd);
    @(negedge Clk);
    check("t4_writes", wr_cnt - w0, 100);

    // Random placements, bases, mirroring and ROM content.
    for (int t = 0; t < 6; t++) begin
      fill_rom(2);
      b = $urandom_range(2800, 0);
      x = $urandom_range(1023, 0);
      y = $urandom_range(1023, 0);
      f = $urandom_range(1, 0);
      w0 = wr_cnt;
      go(b, x, y, f, k, n);
      check("rand_first_rom_addr", rom_addr, b + ((f != 0) ? W - 1 : 0));
      wait_done(nd);
      @(negedge Clk);
      check("rand_writes", wr_cnt - w0, n);
    end

    // Reset 500 edges into a blit, then restart immediately after release.
    fill_rom(0);
    go(0, 5, 5, 0, k, n);
    repeat (500) @(posedge Clk);
    #1;
    Reset = 1'b1;
    wq.delete();
    dq.delete();
    nd--;
    #1;
    check("mid_rst_fb_we", fb_we, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    @(negedge Clk);
    check("mid_rst_fb_we_hold", fb_we, 0);
    Reset = 1'b0;
    w0 = wr_cnt;
    go(40, 20, 30, 1, k, n);
    wait_done(nd);
    @(negedge Clk);
    check("post_rst_writes", wr_cnt - w0, n);

    // start held for 2000 cycles: one blit, a second accepted right after DONE.
    fill_rom(2);
    model_blit(100, 200, 100, 1, n);
    sprite_base = 19'd100;
    pos_x = 10'd200;
    pos_y = 10'd100;
    flip = 1'b1;
    start = 1'b1;
    @(posedge Clk);
    #1;
    k = cyc;
    dq.push_back(k + LAT);
    dq.push_back(k + LAT + 2 + LAT);
    w0 = nd;
    nd += 2;
    fork
      begin
        repeat (1999) @(posedge Clk);
        #1;
        start = 1'b0;
      end
      begin
        wait_done(w0 + 1);
        model_blit(100, 200, 100, 1, n);
        wait_done(w0 + 2);
      end
    join
    repeat (30) @(negedge Clk);
    check("held_busy_idle", busy, 0);
    check("held_done_count", done_cnt, w0 + 2);
    check("held_writes_left", wq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
